cic_sample_buffer: RTL and testbench



---
 rtl/cic_sample_buffer_pkg.sv | 21 ++
 rtl/cic_sample_buffer_if.sv | 24 ++
 rtl/cic_sample_buffer_fifo.sv | 86 ++++++++
 rtl/cic_sample_buffer.sv | 121 ++++++++++++
 tb/tb_cic_sample_buffer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cic_sample_buffer_pkg.sv
// Shared types and constants for the CIC sample buffer.
package cic_buffer_pkg;

    localparam int DATA_W = 14;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Averaging length is 2^avg_sel samples.
    typedef enum logic [1:0] {
        AVG1 = 2'd0,
        AVG2 = 2'd1,
        AVG4 = 2'd2,
        AVG8 = 2'd3
    } avg_len_e;

    // Counter value of the final sample in a block of 2^len samples.
    function automatic logic [2:0] block_last(avg_len_e len);
        return 3'((4'd1 << len) - 4'd1);
    endfunction

endpackage

// File: rtl/cic_sample_buffer_if.sv
// Readout handshake between the sample buffer and its consumer.
interface cic_sample_buffer_if
    import cic_buffer_pkg::*;
#(
    parameter int W = DATA_W
);
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;

    // Buffer side presents the head word.
    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    // Consumer side accepts the head word.
    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/cic_sample_buffer_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop_req,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;
    logic          push_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = pop_req & ~empty;
    assign push_ok  = push & (~full | pop);
    assign rd_valid = ~empty;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state for pointers, count and memory; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage words; reset to zero so the head word reads 0 after reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        // One storage word.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) mem_q[gi] <= '0;
            else          mem_q[gi] <= mem_d[gi];
        end
    end

endmodule

// File: rtl/cic_sample_buffer.sv
// Captures decimated CIC samples on the divided-clock rising edge,
// box-car averages 2^avg_sel of them and queues results for readout.
module cic_sample_buffer
    import cic_buffer_pkg::*;
#(
    parameter int DATA_W = cic_buffer_pkg::DATA_W,
    parameter int DEPTH  = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_clk,
    input  logic                     enable,
    input  logic [1:0]               avg_sel,
    input  logic                     clear,
    cic_sample_buffer_if.master      rd,
    output logic [CW-1:0]            count,
    output logic                     overflow
);

    localparam int ACC_W = DATA_W + 3;

    logic                    sclk_q, sclk_d;
    logic                    cap_pend_q, cap_pend_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]              cnt_q, cnt_d;
    avg_len_e                avg_q, avg_d;
    logic                    overflow_q, overflow_d;

    logic                    rise;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic                    push;
    logic [DATA_W-1:0]       push_data;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Edge detect, accumulation and overflow tracking.
    always_comb begin
        rise       = sample_clk & ~sclk_q & enable;
        sample_ext = $signed({{3{sample_in[DATA_W-1]}}, sample_in});
        sum        = acc_q + sample_ext;
        shifted    = sum >>> avg_q;
        push_data  = shifted[DATA_W-1:0];

        sclk_d     = sample_clk;
        cap_pend_d = rise;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        avg_d      = (cnt_q == 3'd0) ? avg_len_e'(avg_sel) : avg_q;
        overflow_d = overflow_q;
        push       = 1'b0;

        if (!enable) begin
            acc_d = '0;
            cnt_d = 3'd0;
        end else if (cap_pend_q) begin
            if (cnt_q == block_last(avg_q)) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = 3'd0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 3'd1;
            end
        end

        if (push && fifo_full && !(rd.rd_valid && rd.rd_ready)) begin
            overflow_d = 1'b1;
        end

        if (clear) begin
            cap_pend_d = 1'b0;
            acc_d      = '0;
            cnt_d      = 3'd0;
            overflow_d = 1'b0;
            push       = 1'b0;
        end
    end

    // Capture-path state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q     <= 1'b0;
            cap_pend_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= 3'd0;
            avg_q      <= AVG1;
            overflow_q <= 1'b0;
        end else begin
            sclk_q     <= sclk_d;
            cap_pend_q <= cap_pend_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            avg_q      <= avg_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    sample_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop_req   (rd.rd_ready),
        .rd_valid  (rd.rd_valid),
        .rd_data   (rd.rd_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_cic_sample_buffer.sv
// Directed bench for cic_sample_buffer with a queue-based scoreboard.
module tb_cic_sample_buffer;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [13:0] sample_in = '0;
    logic               sample_clk = 1'b0;
    logic               enable = 1'b1;
    logic [1:0]         avg_sel = 2'd0;
    logic               clear = 1'b0;
    logic [3:0]         count;
    logic               overflow;

    int checks = 0;
    int failures = 0;
    logic [13:0] exp_q[$];

    cic_sample_buffer_if #(.W(14)) rd_if ();

    cic_sample_buffer u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_in  (sample_in),
        .sample_clk (sample_clk),
        .enable     (enable),
        .avg_sel    (avg_sel),
        .clear      (clear),
        .rd         (rd_if),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic expect_word(input int v);
        exp_q.push_back(14'(v));
    endtask

    // One sample_clk rise carrying value v; leaves enough cycles for E1/E2.
    task automatic do_rise(input int v);
        @(posedge clk); #1;
        sample_in  = 14'(v);
        sample_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 sample_clk = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Hold rd_ready until the FIFO empties, bounded.
    task automatic drain(input string name);
        int n = 0;
        @(posedge clk); #1;
        rd_if.rd_ready = 1'b1;
        while (count != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(count), 0);
        rd_if.rd_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: each accepted word is compared with the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && !clear && rd_if.rd_valid && rd_if.rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_word: got %0d expected none", $signed(rd_if.rd_data));
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== e) begin
                    failures++;
                    $display("FAIL rd_word: got %0d expected %0d",
                             $signed(rd_if.rd_data), $signed(e));
                end else begin
                    $display("ok   rd_word: %0d", $signed(rd_if.rd_data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rd_if.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_valid", int'(rd_if.rd_valid), 0);
        chk("reset_rd_data", int'(rd_if.rd_data), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_overflow", int'(overflow), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single sample, no averaging, latency check.
        @(posedge clk); #1;
        sample_in  = 14'h0123;
        sample_clk = 1'b1;
        expect_word(14'h0123);
        @(posedge clk);            // E1
        @(negedge clk);
        chk("lat_e1_rd_valid", int'(rd_if.rd_valid), 0);
        @(posedge clk);            // E2
        @(negedge clk);
        chk("lat_e2_rd_valid", int'(rd_if.rd_valid), 1);
        chk("single_count", int'(count), 1);
        @(posedge clk); #1;
        sample_clk     = 1'b0;
        rd_if.rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_if.rd_ready = 1'b0;
        @(negedge clk);
        chk("pop_rd_valid", int'(rd_if.rd_valid), 0);
        chk("pop_count", int'(count), 0);

        // Average of 4, positive and negative.
        avg_sel = 2'd2;
        do_rise(100); do_rise(101); do_rise(102); do_rise(104);
        expect_word(101);
        do_rise(-1); do_rise(-2); do_rise(-2); do_rise(-2);
        expect_word(-2);
        @(negedge clk);
        chk("avg4_count", int'(count), 2);
        drain("avg4_drain");

        // Overflow with 9 rises and no reader.
        avg_sel = 2'd0;
        for (int i = 0; i < 9; i++) begin
            do_rise(10 + i);
            if (i < 8) expect_word(10 + i);
        end
        @(negedge clk);
        chk("ovf_count", int'(count), 8);
        chk("ovf_flag", int'(overflow), 1);
        drain("ovf_drain");
        chk("ovf_sticky", int'(overflow), 1);
        do_rise(77); do_rise(78);
        @(negedge clk);
        chk("pre_clear_count", int'(count), 2);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_count", int'(count), 0);
        chk("clear_overflow", int'(overflow), 0);
        chk("clear_rd_valid", int'(rd_if.rd_valid), 0);

        // Full FIFO with a pop in the same cycle as the 9th push.
        for (int i = 0; i < 8; i++) begin
            do_rise(20 + i);
            expect_word(20 + i);
        end
        @(posedge clk); #1;
        sample_in  = 14'(28);
        sample_clk = 1'b1;
        expect_word(28);
        @(posedge clk); #1;        // E1
        rd_if.rd_ready = 1'b1;
        @(posedge clk); #1;        // E2: push and pop together
        rd_if.rd_ready = 1'b0;
        sample_clk     = 1'b0;
        @(negedge clk);
        chk("full_pop_count", int'(count), 8);
        chk("full_pop_overflow", int'(overflow), 0);
        drain("full_pop_drain");

        // Average of 8 with a discarded partial block.
        avg_sel = 2'd3;
        do_rise(1000); do_rise(2000); do_rise(3000);
        @(posedge clk); #1;
        enable = 1'b0;
        do_rise(5000);
        @(posedge clk); #1;
        enable = 1'b1;
        do_rise(10); do_rise(20); do_rise(30); do_rise(40);
        do_rise(50); do_rise(60); do_rise(70); do_rise(81);
        expect_word(45);
        @(negedge clk);
        chk("avg8_count", int'(count), 1);
        drain("avg8_drain");

        // Asynchronous reset mid-operation.
        avg_sel = 2'd0;
        do_rise(500); do_rise(501);
        avg_sel = 2'd1;
        repeat (2) @(posedge clk);
        do_rise(7);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_rd_valid", int'(rd_if.rd_valid), 0);
        chk("arst_rd_data", int'(rd_if.rd_data), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_overflow", int'(overflow), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        do_rise(300); do_rise(303);
        expect_word(301);
        @(negedge clk);
        chk("post_rst_count", int'(count), 1);
        drain("post_rst_drain");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
